// File: rtl/regfile_mp.sv
// Parametrised integer register file with write bypass,
// hardwired zero register and per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 64,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic [ADDR_W-1:0] rs1_in,
  input  logic [ADDR_W-1:0] rs2_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              rd_write_in,
  input  logic [XLEN-1:0]   rd_value_in,
  input  logic              issue_valid_in,
  input  logic [ADDR_W-1:0] issue_rd_in,
  output logic [XLEN-1:0]   rs1_value_out,
  output logic [XLEN-1:0]   rs2_value_out,
  output logic              rs1_busy_out,
  output logic              rs2_busy_out
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [XLEN-1:0]  r_rs1_val;
  logic [XLEN-1:0]  r_rs2_val;
  logic             r_rs1_busy;
  logic             r_rs2_busy;

  logic             w_wr_en;
  logic             w_iss_en;
  logic [NREGS-1:0] w_busy_nxt;
  logic [XLEN-1:0]  w_rs1_val;
  logic [XLEN-1:0]  w_rs2_val;

  // Qualify write and issue; register 0 absorbs neither when hardwired.
  always_comb begin
    w_wr_en  = rd_write_in &&
               !(ZR && (rd_in == '0));
    w_iss_en = issue_valid_in && !stall_in &&
               !(ZR && (issue_rd_in == '0));
  end

  // Post-edge busy vector: writeback clears, newer issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rd_write_in)
      w_busy_nxt[rd_in] = 1'b0;
    if (w_iss_en)
      w_busy_nxt[issue_rd_in] = 1'b1;
    if (ZR)
      w_busy_nxt[0] = 1'b0;
  end

  // Read data with same-edge writeback bypass and zero register.
  always_comb begin
    w_rs1_val = r_regs[rs1_in];
    w_rs2_val = r_regs[rs2_in];
    if (w_wr_en && (rd_in == rs1_in))
      w_rs1_val = rd_value_in;
    if (w_wr_en && (rd_in == rs2_in))
      w_rs2_val = rd_value_in;
    if (ZR && (rs1_in == '0))
      w_rs1_val = '0;
    if (ZR && (rs2_in == '0))
      w_rs2_val = '0;
  end

  // Register array: cleared on reset, written on writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[rd_in] <= rd_value_in;
    end
  end

  // Busy scoreboard state.
  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  // Registered read ports; held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1_val  <= '0;
      r_rs2_val  <= '0;
      r_rs1_busy <= 1'b0;
      r_rs2_busy <= 1'b0;
    end else if (!stall_in) begin
      r_rs1_val  <= w_rs1_val;
      r_rs2_val  <= w_rs2_val;
      r_rs1_busy <= w_busy_nxt[rs1_in];
      r_rs2_busy <= w_busy_nxt[rs2_in];
    end
  end

  assign rs1_value_out = r_rs1_val;
  assign rs2_value_out = r_rs2_val;
  assign rs1_busy_out  = r_rs1_busy;
  assign rs2_busy_out  = r_rs2_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised integer register file for the Riscy_SoC decode/operand-fetch stage.
- Generalises the fixed 64x64 two-read/one-write file to configurable width and depth.
- Adds synchronous reset, write-to-read bypass, an optional hardwired-zero register and a per-register busy scoreboard for hazard detection.
- Sits between decode (issues read and destination addresses) and writeback (commits results).

Parameters:
- XLEN, 64, data width of each register in bits.
- NREGS, 64, number of architectural registers; power of two, at least 2.
- ADDR_W, 6, address width; must equal log2(NREGS).
- ZERO_REG, 1, if 1 then register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_in  in  1  holds read outputs and suppresses issue when high.
- rs1_in  in  ADDR_W  read address, port 1.
- rs2_in  in  ADDR_W  read address, port 2.
- rd_in  in  ADDR_W  writeback destination address.
- rd_write_in  in  1  writeback enable.
- rd_value_in  in  XLEN  writeback data.
- issue_valid_in  in  1  an instruction with a destination is issuing this cycle.
- issue_rd_in  in  ADDR_W  destination register of the issuing instruction.
- rs1_value_out  out  XLEN  registered read data, port 1.
- rs2_value_out  out  XLEN  registered read data, port 2.
- rs1_busy_out  out  1  registered busy flag for the register addressed on port 1.
- rs2_busy_out  out  1  registered busy flag for the register addressed on port 2.

Behaviour:
- Reset (clk edge with reset=1): all NREGS registers cleared to 0, all busy bits cleared, all four outputs driven to 0.
  - Reset dominates stall, write and issue in the same cycle.
  - Reset asserted mid-operation discards all in-flight state.
- Read latency is 1 cycle. With stall_in=0 and reset=0, at edge N each port samples its address and drives value and busy from edge N onward.
- With stall_in=1, value and busy outputs hold their previous contents. Writes still commit.
- Write: on an edge with rd_write_in=1 the register at rd_in takes rd_value_in.
  - When ZERO_REG=1 and rd_in=0 the write is dropped.
- Bypass: if a port reads address A on the same edge that A is written (non-zero, or ZERO_REG=0), the port outputs rd_value_in, not the stale array value. Both ports bypass independently; rs1_in=rs2_in=rd_in bypasses to both.
- Zero register, ZERO_REG=1: a read of address 0 returns 0 and busy 0, regardless of writes or issues.
- Scoreboard: one busy bit per register.
  - Set: an edge with issue_valid_in=1, stall_in=0, and issue_rd_in not the hardwired zero register sets busy[issue_rd_in].
  - Clear: an edge with rd_write_in=1 clears busy[rd_in].
  - Same register set and cleared on one edge: set wins, because the newer producer is still outstanding.
  - Issue with stall_in=1 is ignored.
- Busy output rule: sampled busy reflects the post-edge state.
  - Writeback clearing A on the same edge as a read of A gives busy 0, unless A is also being issued that edge, in which case busy is 1.
- Writes to a register that is not busy are legal and simply update it.
- Widths:
  - No arithmetic is performed.
  - Address inputs are used unsigned at full width.
  - Addresses at or above NREGS cannot occur because ADDR_W=log2(NREGS).
- No combinational path from inputs to outputs; all outputs are flops.

Test Plan:
- Reset, then read all addresses (stall_in=0) -> every value 0 and busy 0, one cycle after each address is presented.
- Write 0xDEAD_BEEF_0000_0001 to r5; next cycle read rs1=5, rs2=5 -> both outputs 0xDEAD_BEEF_0000_0001 one cycle later.
- Same-edge bypass: rd_write_in=1, rd_in=7, value 0x1234, rs1=7 -> rs1_value_out=0x1234 after that edge. Also write r0=0xFF with ZERO_REG=1 -> reading r0 returns 0.
- Stall: read r5 (0xAA), then stall_in=1 while changing rs1 to r6 and writing r5=0xBB -> output stays 0xAA. Deassert stall -> output r6 value. A later read of r5 returns 0xBB.
- Scoreboard:
  - Issue rd=3, then read r3 -> busy 1.
  - Writeback r3 -> busy 0.
  - Issue rd=3 and writeback r3 on the same edge -> busy stays 1.
  - Issue rd=0 -> busy 0.
- Reset mid-operation: registers r1..r4 written non-zero, r2 busy, outputs non-zero; assert reset for one edge together with a write to r1 -> all outputs 0, subsequent reads of r1..r4 return 0 with busy 0.
